// File: rtl/calc_seq_param.sv
// Sequential calculator: WIDTH-bit operand registers, a 2*WIDTH-bit accumulator,
// an 8-operation ALU with a shift-add multiplier, and a step-driven control FSM.
module calc_seq_param #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   dados,
  input  logic               instrucao,
  input  logic               chain,
  input  logic [2:0]         op,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               carry,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_EXEC  = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_PASS = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  // Kept as plain bits so codes 5-7 stay representable and recoverable.
  logic [2:0]    state_q;
  logic [2:0]    op_q;
  logic          use_acc;
  logic [CW-1:0] cnt;
  logic [RW-1:0] partial;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] bop;
  logic [RW:0]   sum;
  logic [RW-1:0] alu_res;
  logic          alu_carry;
  logic [RW-1:0] mul_next;

  always_comb begin
    a_ext     = {{WIDTH{1'b0}}, reg_a};
    bop       = use_acc ? acc : {{WIDTH{1'b0}}, reg_b};
    sum       = {1'b0, a_ext} + {1'b0, bop};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum[RW-1:0];
        alu_carry = sum[RW];
      end
      OP_SUB: begin
        alu_res   = a_ext - bop;
        alu_carry = (a_ext < bop);
      end
      OP_AND:  alu_res = a_ext & bop;
      OP_OR:   alu_res = a_ext | bop;
      OP_XOR:  alu_res = a_ext ^ bop;
      OP_PASS: alu_res = a_ext;
      default: alu_res = '0;
    endcase
    mul_next = partial + (reg_a[cnt] ? (bop << cnt) : '0);
  end

  // Handshake: instrucao is a level sampled each edge and only accepted in
  // IDLE/GOT_A; busy covers EXEC+MUL, done is a one-cycle pulse after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      reg_a   <= '0;
      reg_b   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      op_q    <= '0;
      use_acc <= 1'b0;
      cnt     <= '0;
      partial <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instrucao) begin
            reg_a <= dados;
            if (chain) begin
              op_q    <= op;
              use_acc <= 1'b1;
              state_q <= S_EXEC;
            end else begin
              state_q <= S_GOT_A;
            end
          end
        end
        S_GOT_A: begin
          if (instrucao) begin
            reg_b   <= dados;
            op_q    <= op;
            use_acc <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            partial <= '0;
            cnt     <= '0;
            state_q <= S_MUL;
          end else begin
            acc     <= alu_res;
            carry   <= alu_carry;
            zero    <= (alu_res == '0);
            state_q <= S_DONE;
          end
        end
        S_MUL: begin
          partial <= mul_next;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            acc     <= mul_next;
            carry   <= 1'b0;
            zero    <= (mul_next == '0);
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == S_EXEC) || (state_q == S_MUL);
  assign done  = (state_q == S_DONE);
  assign state = state_q;

endmodule
